// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and helpers for the UART frame receiver.
// Holds the FSM state encoding, the default start-of-frame marker and the word-count helper.
package uart_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_CHK,
      ST_COMMIT
   } state_e;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   function automatic int calc_n_words(input int w_out, input int bpw);
      return (w_out + bpw - 1) / bpw;
   endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// rtl/axis_hold_reg.sv - one-beat output holding register with valid/ready handshake.
// full means a beat is held that is not being taken this cycle, so a load now would be lost.
module axis_hold_reg #(
   parameter int W = 224
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         full
);

   logic [W-1:0] q_q;
   logic         valid_q;

   assign full    = valid_q & ~m_ready;
   assign q       = q_q;
   assign m_valid = valid_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else if (load && !full) begin
         q_q     <= d;
         valid_q <= 1'b1;
      end else if (m_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SOF-framed byte-to-wide-beat assembler with timeout and error pulses.
// Optional trailing XOR checksum word is enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int                       BITS_PER_WORD = 8,
   parameter int                       W_OUT         = 224,
   parameter logic [BITS_PER_WORD-1:0] SOF_WORD      = BITS_PER_WORD'(SOF_DEFAULT),
   parameter int                       TIMEOUT_CLKS  = 200_000_000 / 9600 * 20
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   input  logic [BITS_PER_WORD-1:0] s_data,
   input  logic                     m_ready,
   output logic                     m_valid,
   output logic [W_OUT-1:0]         m_data,
   output logic                     err_sync,
   output logic                     err_ovf,
   output logic                     err_chk
);

   localparam int N_WORDS = calc_n_words(W_OUT, BITS_PER_WORD);
   localparam int W_CNT   = $clog2(N_WORDS + 1);
   localparam int W_SR    = N_WORDS * BITS_PER_WORD;
   localparam int W_TMR   = $clog2(TIMEOUT_CLKS + 1);

   state_e             state_q;
   logic [W_CNT-1:0]   cnt_q;
   logic [W_TMR-1:0]   tmr_q;
   logic [W_SR-1:0]    sr_q;
   logic               err_sync_q;
   logic               err_ovf_q;
   logic               hold_full;
   logic               hold_load;
   logic               is_sof;
   logic               last_word;
   logic               tmr_expired;

   assign is_sof      = (s_data == SOF_WORD);
   assign last_word   = (cnt_q == W_CNT'(N_WORDS - 1));
   assign tmr_expired = (tmr_q == W_TMR'(TIMEOUT_CLKS - 1));
   assign hold_load   = (state_q == ST_COMMIT) && !hold_full;
   assign err_sync    = err_sync_q;
   assign err_ovf     = err_ovf_q;

`ifdef UART_FRAME_CHECKSUM_EN
   logic [BITS_PER_WORD-1:0] chk_q;
   logic                     err_chk_q;
   assign err_chk = err_chk_q;
`else
   assign err_chk = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         tmr_q      <= '0;
         sr_q       <= '0;
         err_sync_q <= 1'b0;
         err_ovf_q  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         chk_q      <= '0;
         err_chk_q  <= 1'b0;
`endif
      end else begin
         err_sync_q <= 1'b0;
         err_ovf_q  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         err_chk_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (s_valid && is_sof) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
                  tmr_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk_q   <= '0;
`endif
               end
            end
            ST_DATA: begin
               if (s_valid) begin
                  sr_q[cnt_q*BITS_PER_WORD +: BITS_PER_WORD] <= s_data;
                  cnt_q <= cnt_q + W_CNT'(1);
                  tmr_q <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk_q <= chk_q ^ s_data;
                  if (last_word) state_q <= ST_CHK;
`else
                  if (last_word) state_q <= ST_COMMIT;
`endif
               end else if (tmr_expired) begin
                  err_sync_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + W_TMR'(1);
               end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHK: begin
               if (s_valid) begin
                  tmr_q <= '0;
                  if (s_data == chk_q) begin
                     state_q <= ST_COMMIT;
                  end else begin
                     err_chk_q <= 1'b1;
                     state_q   <= ST_IDLE;
                  end
               end else if (tmr_expired) begin
                  err_sync_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + W_TMR'(1);
               end
            end
`endif
            ST_COMMIT: begin
               err_ovf_q <= hold_full;
               // The UART cannot stall, so an SOF landing here must open the next frame.
               if (s_valid && is_sof) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
                  tmr_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                  chk_q   <= '0;
`endif
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   axis_hold_reg #(
      .W (W_OUT)
   ) u_hold (
      .clk     (clk),
      .rstn    (rstn),
      .load    (hold_load),
      .d       (sr_q[W_OUT-1:0]),
      .q       (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .full    (hold_full)
   );

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - directed self-checking bench for uart_frame_rx.
module tb_uart_frame_rx;

   localparam int NW = 28;
   localparam int TO = 40;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         s_valid = 1'b0;
   logic [7:0]   s_data = 8'h00;
   logic         m_ready = 1'b1;
   logic         m_valid;
   logic [223:0] m_data;
   logic         err_sync;
   logic         err_ovf;
   logic         err_chk;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_sync  = 0;
   int           n_ovf   = 0;
   int           n_chk   = 0;
   int           n_beat  = 0;
   int           b_sync, b_ovf, b_chk, b_beat;
   logic [223:0] last_beat = '0;
   logic [223:0] exp_beat;
   logic [223:0] exp_a;
   logic [7:0]   frame [NW];
   logic [7:0]   xsum;

   always #5 clk = ~clk;

   uart_frame_rx #(
      .TIMEOUT_CLKS (TO)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .err_sync (err_sync),
      .err_ovf  (err_ovf),
      .err_chk  (err_chk)
   );

   always @(negedge clk) begin
      if (err_sync) n_sync++;
      if (err_ovf)  n_ovf++;
      if (err_chk)  n_chk++;
      if (m_valid && m_ready) begin
         n_beat++;
         last_beat = m_data;
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      b_sync = n_sync;
      b_ovf  = n_ovf;
      b_chk  = n_chk;
      b_beat = n_beat;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'h00;
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < NW; i++) frame[i] = base + 8'(i);
   endtask

   task automatic send_body();
      xsum = 8'h00;
      send(8'hA5);
      for (int i = 0; i < NW; i++) begin
         exp_beat[i*8 +: 8] = frame[i];
         xsum = xsum ^ frame[i];
         send(frame[i]);
      end
   endtask

   task automatic send_frame();
      send_body();
`ifdef UART_FRAME_CHECKSUM_EN
      send(xsum);
`endif
   endtask

   initial begin
      // reset state
      tick(3);
      check("rst_m_valid", 256'(m_valid), 256'(0));
      check("rst_m_data", 256'(m_data), 256'(0));
      check("rst_errs", 256'({err_sync, err_ovf, err_chk}), 256'(0));
      rstn = 1'b1;
      tick(2);

      // basic frame with latency check
      snap();
      fill(8'h00);
      send_frame();
      check("basic_lat1", 256'(m_valid), 256'(0));
      tick(1);
      check("basic_lat2", 256'(m_valid), 256'(1));
      check("basic_lsb", 256'(m_data[7:0]), 256'(8'h00));
      check("basic_msb", 256'(m_data[223:216]), 256'(8'h1B));
      check("basic_data", 256'(m_data), 256'(exp_beat));
      tick(1);
      check("basic_fall", 256'(m_valid), 256'(0));
      tick(3);
      check("basic_beats", 256'(n_beat - b_beat), 256'(1));

      // garbage then a frame with an embedded SOF value
      snap();
      send(8'h11);
      send(8'h22);
      fill(8'h30);
      frame[5] = 8'hA5;
      send_frame();
      tick(4);
      check("garb_beats", 256'(n_beat - b_beat), 256'(1));
      check("garb_data", 256'(last_beat), 256'(exp_beat));
      check("garb_w5", 256'(last_beat[47:40]), 256'(8'hA5));
      check("garb_errs", 256'((n_sync - b_sync) + (n_ovf - b_ovf) + (n_chk - b_chk)), 256'(0));

      // timeout after 10 words
      snap();
      send(8'hA5);
      for (int i = 0; i < 10; i++) send(8'(8'h50 + i));
      tick(35);
      check("to_early", 256'(n_sync - b_sync), 256'(0));
      tick(25);
      check("to_sync", 256'(n_sync - b_sync), 256'(1));
      check("to_nobeat", 256'(n_beat - b_beat), 256'(0));
      fill(8'h80);
      send_frame();
      tick(4);
      check("to_next_beat", 256'(n_beat - b_beat), 256'(1));
      check("to_next_data", 256'(last_beat), 256'(exp_beat));
      check("to_sync_once", 256'(n_sync - b_sync), 256'(1));

      // backpressure and overflow
      snap();
      m_ready = 1'b0;
      fill(8'h40);
      send_frame();
      exp_a = exp_beat;
      tick(4);
      check("bp_valid", 256'(m_valid), 256'(1));
      check("bp_data", 256'(m_data), 256'(exp_a));
      fill(8'hC0);
      send_frame();
      tick(4);
      check("bp_ovf", 256'(n_ovf - b_ovf), 256'(1));
      check("bp_stable", 256'(m_data), 256'(exp_a));
      check("bp_valid2", 256'(m_valid), 256'(1));
      m_ready = 1'b1;
      tick(4);
      check("bp_beats", 256'(n_beat - b_beat), 256'(1));
      check("bp_beat_data", 256'(last_beat), 256'(exp_a));
      check("bp_drained", 256'(m_valid), 256'(0));

      // reset mid-frame while a beat is held
      m_ready = 1'b0;
      fill(8'h20);
      send_frame();
      tick(3);
      send(8'hA5);
      for (int i = 0; i < 15; i++) send(8'(8'h70 + i));
      rstn = 1'b0;
      tick(2);
      check("mrst_valid", 256'(m_valid), 256'(0));
      check("mrst_data", 256'(m_data), 256'(0));
      check("mrst_errs", 256'({err_sync, err_ovf, err_chk}), 256'(0));
      rstn = 1'b1;
      m_ready = 1'b1;
      tick(2);
      snap();
      fill(8'h60);
      send_frame();
      tick(4);
      check("mrst_beats", 256'(n_beat - b_beat), 256'(1));
      check("mrst_data2", 256'(last_beat), 256'(exp_beat));

`ifdef UART_FRAME_CHECKSUM_EN
      // checksum good and bad; XOR of 0x01..0x1C is 0x1C
      snap();
      fill(8'h01);
      send_body();
      send(8'h1C);
      tick(4);
      check("chk_good_beat", 256'(n_beat - b_beat), 256'(1));
      check("chk_good_data", 256'(last_beat), 256'(exp_beat));
      check("chk_good_err", 256'(n_chk - b_chk), 256'(0));
      snap();
      send_body();
      send(8'h1D);
      tick(4);
      check("chk_bad_err", 256'(n_chk - b_chk), 256'(1));
      check("chk_bad_beat", 256'(n_beat - b_beat), 256'(0));
`else
      check("chk_tied0", 256'(n_chk), 256'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
